// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter slice.
//   - default geometry (DEPTH/AW/DW)
//   - controller state enum (INIT clears memory, RUN arbitrates)
//   - rr_pick: two-way round-robin grant selection used by rr_arb2
package dmem_pkg;

    localparam int unsigned DEPTH_DEF = 32;
    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned DW_DEF    = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One-hot grant for a two-bit request vector. ptr=0 favours requester 0
    // on contention, ptr=1 favours requester 1.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] g;
        g = '0;
        case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = ptr ? 2'b10 : 2'b01;
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports, the memory port and
// the busy flag of dmem_arbiter.
//   master : environment side (requesters 0/1 and the memory model)
//   slave  : arbiter side
// Requester N: reqN/weN/addrN/wdataN in, gntN/rvalidN/rdataN out.
// Memory: mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in (1-cycle latency).
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);

    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport master (
        output req0, we0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, addr1, wdata1,
        input  gnt1, rvalid1, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, addr1, wdata1,
        output gnt1, rvalid1, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   en       : arbitration enabled (grant forced to 0 otherwise)
//   req[1:0] : request vector
//   grant    : one-hot combinational grant
// The pointer remembers who was granted last so contention goes to the other
// requester; it only moves on a cycle that actually grants.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = '0;
        if (en) begin
            grant = rr_pick(req, ptr);
        end
    end

    // After granting requester 0, favour requester 1 next, and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the pipeline MEM
// stage (requester 0) and a debug/DMA port (requester 1).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dmem_arbiter_if slave port (requesters, memory, busy)
// After reset the block spends DEPTH cycles writing each word with its own
// address (busy=1), then arbitrates one access per cycle. Grants are
// combinational; read data returns one cycle after the grant and rdataN
// holds its last value between reads.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
)(
    input logic          clk,
    input logic          rst,
    dmem_arbiter_if.slave bus
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;

    logic [1:0]    req;
    logic [1:0]    grant;
    logic          run;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic [1:0]    rvalid_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    assign run = (state == RUN);
    assign req = {bus.req1, bus.req0};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (run),
        .req   (req),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state plus the memory-port mux. The rst term in INIT keeps the
    // write strobe low while reset is held, since the strobe is otherwise
    // driven combinationally from the state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            INIT: begin
                mem_en    = ~rst;
                mem_we    = ~rst;
                mem_addr  = cnt;
                mem_wdata = DW'(cnt);
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            RUN: begin
                if (grant[0]) begin
                    mem_en    = 1'b1;
                    mem_we    = bus.we0;
                    mem_addr  = bus.addr0;
                    mem_wdata = bus.wdata0;
                end else if (grant[1]) begin
                    mem_en    = 1'b1;
                    mem_we    = bus.we1;
                    mem_addr  = bus.addr1;
                    mem_wdata = bus.wdata1;
                end
            end
            default: begin
                state_nxt = INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A read granted this cycle returns next cycle; reset drops any return
    // still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= grant & {~bus.we1, ~bus.we0};
        end
    end

    // Read data is forwarded straight from memory in the return cycle and
    // captured so it can be held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid_q[0]) begin
                rdata0_q <= bus.mem_rdata;
            end
            if (rvalid_q[1]) begin
                rdata1_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.gnt0      = grant[0];
    assign bus.gnt1      = grant[1];
    assign bus.rvalid0   = rvalid_q[0];
    assign bus.rvalid1   = rvalid_q[1];
    assign bus.rdata0    = rvalid_q[0] ? bus.mem_rdata : rdata0_q;
    assign bus.rdata1    = rvalid_q[1] ? bus.mem_rdata : rdata1_q;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.busy      = (state == INIT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic for
// dmem_arbiter, checked every cycle against a behavioural model.
module tb_dmem_arbiter;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory the arbiter talks to: one-cycle read latency.
    logic [DW-1:0] env_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= env_mem[bus.mem_addr];
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endfunction

    // ---------------- behavioural model ----------------
    int            m_init;     // init writes done since reset; DEPTH means running
    int            m_last;     // requester granted most recently (1 after reset => 0 wins)
    bit            m_rv  [2];  // read return expected this cycle
    logic [DW-1:0] m_exp [2];  // data of that return
    logic [DW-1:0] m_hold[2];  // last returned data
    logic [DW-1:0] m_mem [DEPTH];

    // Which requester must be granted now (-1: none), from the stated rules.
    function automatic int pick();
        if (rst || m_init < DEPTH) return -1;
        if (bus.req0 && bus.req1) return (m_last == 0) ? 1 : 0;
        if (bus.req0) return 0;
        if (bus.req1) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_init    <= 0;
            m_last    <= 1;
            m_rv[0]   <= 1'b0;
            m_rv[1]   <= 1'b0;
            m_hold[0] <= '0;
            m_hold[1] <= '0;
        end else if (m_init < DEPTH) begin
            m_mem[m_init] <= DW'(m_init);
            m_init        <= m_init + 1;
        end else begin
            if (m_rv[0]) m_hold[0] <= m_exp[0];
            if (m_rv[1]) m_hold[1] <= m_exp[1];
            m_rv[0] <= (pick() == 0) && !bus.we0;
            m_rv[1] <= (pick() == 1) && !bus.we1;
            if (pick() == 0) begin
                m_last <= 0;
                if (bus.we0) m_mem[bus.addr0] <= bus.wdata0;
                else         m_exp[0] <= m_mem[bus.addr0];
            end else if (pick() == 1) begin
                m_last <= 1;
                if (bus.we1) m_mem[bus.addr1] <= bus.wdata1;
                else         m_exp[1] <= m_mem[bus.addr1];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("rst_busy",   bus.busy,    1);
            check("rst_mem_en", bus.mem_en,  0);
            check("rst_mem_we", bus.mem_we,  0);
            check("rst_gnt0",   bus.gnt0,    0);
            check("rst_gnt1",   bus.gnt1,    0);
            check("rst_rvalid0", bus.rvalid0, 0);
            check("rst_rvalid1", bus.rvalid1, 0);
            check("rst_rdata0", bus.rdata0,  0);
            check("rst_rdata1", bus.rdata1,  0);
        end else if (m_init < DEPTH) begin
            check("init_busy",      bus.busy,      1);
            check("init_mem_en",    bus.mem_en,    1);
            check("init_mem_we",    bus.mem_we,    1);
            check("init_mem_addr",  bus.mem_addr,  m_init);
            check("init_mem_wdata", bus.mem_wdata, m_init);
            check("init_gnt0",      bus.gnt0,      0);
            check("init_gnt1",      bus.gnt1,      0);
            check("init_rvalid0",   bus.rvalid0,   0);
            check("init_rvalid1",   bus.rvalid1,   0);
        end else begin
            check("run_busy",   bus.busy,   0);
            check("run_gnt0",   bus.gnt0,   pick() == 0);
            check("run_gnt1",   bus.gnt1,   pick() == 1);
            check("run_mem_en", bus.mem_en, pick() >= 0);
            if (pick() == 0) begin
                check("run_mem_we0",    bus.mem_we,    bus.we0);
                check("run_mem_addr0",  bus.mem_addr,  bus.addr0);
                check("run_mem_wdata0", bus.mem_wdata, bus.wdata0);
            end else if (pick() == 1) begin
                check("run_mem_we1",    bus.mem_we,    bus.we1);
                check("run_mem_addr1",  bus.mem_addr,  bus.addr1);
                check("run_mem_wdata1", bus.mem_wdata, bus.wdata1);
            end else begin
                check("run_mem_we_idle", bus.mem_we, 0);
            end
            check("run_rvalid0", bus.rvalid0, m_rv[0]);
            check("run_rvalid1", bus.rvalid1, m_rv[1]);
            check("run_rdata0",  bus.rdata0,  m_rv[0] ? m_exp[0] : m_hold[0]);
            check("run_rdata1",  bus.rdata1,  m_rv[1] ? m_exp[1] : m_hold[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_reqs();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    // Entered just after the edge that follows reset release; counts busy cycles.
    task automatic init_run(input string tag);
        int nb;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            check({tag, "_addr"}, bus.mem_addr,  i);
            check({tag, "_data"}, bus.mem_wdata, i);
            nb++;
        end
        check({tag, "_len"}, nb, 32);
    endtask

    initial begin
        logic [3:0] seq0;
        logic [3:0] seq1;
        logic       g0;
        logic       g1;
        logic       hit;

        rst        = 1'b1;
        bus.req0   = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1   = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        init_run("init_a");

        // requester 1 reads address 7 alone
        @(posedge clk); #1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd7;
        @(negedge clk);
        check("r1_gnt1", bus.gnt1, 1);
        check("r1_gnt0", bus.gnt0, 0);
        @(posedge clk); #1 idle_reqs();
        @(negedge clk);
        check("r1_rvalid1", bus.rvalid1, 1);
        check("r1_rdata1",  bus.rdata1,  7);
        check("r1_rvalid0", bus.rvalid0, 0);

        // both requesting for 4 cycles
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd2;
        seq0 = '0; seq1 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seq0 = {seq0[2:0], bus.gnt0};
            seq1 = {seq1[2:0], bus.gnt1};
        end
        check("rr_gnt0_seq", seq0, 4'b1010);
        check("rr_gnt1_seq", seq1, 4'b0101);
        @(posedge clk); #1 idle_reqs();

        // write then read back on requester 0
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd5; bus.wdata0 = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_gnt0", bus.gnt0, 1);
        @(posedge clk); #1 bus.we0 = 1'b0;
        @(negedge clk);
        check("rd_gnt0", bus.gnt0, 1);
        @(posedge clk); #1 idle_reqs();
        @(negedge clk);
        check("rd_rvalid0", bus.rvalid0, 1);
        check("rd_rdata0",  bus.rdata0,  32'hDEADBEEF);

        // randomized traffic; each requester holds until granted
        g0 = 1'b0; g1 = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (!bus.req0 || g0) begin
                bus.req0 = ($urandom_range(0, 3) != 0);
                bus.we0 = 1'($urandom_range(0, 1));
                bus.addr0 = AW'($urandom);
                bus.wdata0 = $urandom;
            end
            if (!bus.req1 || g1) begin
                bus.req1 = ($urandom_range(0, 3) != 0);
                bus.we1 = 1'($urandom_range(0, 1));
                bus.addr1 = AW'($urandom);
                bus.wdata1 = $urandom;
            end
            @(negedge clk);
            g0 = bus.gnt0;
            g1 = bus.gnt1;
        end

        // reset in the cycle after a read grant
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd3;
        @(negedge clk);
        check("rrst_gnt0", bus.gnt0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_reqs();
        #1;
        check("rrst_rvalid0", bus.rvalid0, 0);
        check("rrst_rvalid1", bus.rvalid1, 0);
        check("rrst_busy",    bus.busy,    1);
        check("rrst_rdata0",  bus.rdata0,  0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;

        // reset in the middle of init, at counter 10
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            hit = bus.busy && (bus.mem_addr == 5'd10);
        end
        check("irst_reach10", hit, 1);
        #1 rst = 1'b1;
        #1;
        check("irst_busy",    bus.busy,    1);
        check("irst_mem_en",  bus.mem_en,  0);
        check("irst_mem_we",  bus.mem_we,  0);
        check("irst_gnt0",    bus.gnt0,    0);
        check("irst_gnt1",    bus.gnt1,    0);
        check("irst_rvalid0", bus.rvalid0, 0);
        @(posedge clk); #1 rst = 1'b0;
        init_run("init_b");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
